// File: rtl/mem_arb_pkg.sv
// Shared defaults and state encoding for the
// two-port memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 96;
  localparam int DEPTH      = 1 << ADDR_W_DEF;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; ptr marks the
// port that wins the next tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr;

  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (req == 2'b11): gnt = ptr ? 2'b10 : 2'b01;
      (req == 2'b01): gnt = 2'b01;
      (req == 2'b10): gnt = 2'b10;
      default:        gnt = 2'b00;
    endcase
  end

  // The loser of the latest grant owns the next tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (advance && (gnt != 2'b00)) begin
      ptr <= gnt[0];
    end
  end

endmodule

// File: rtl/mem_arb_2p.sv
// Two-port round-robin front end for a single-port
// synchronous memory with optional zero-fill.
module mem_arb_2p
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_ceb,
  output logic              mem_web,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              init_busy
);

  localparam state_t RST_ST =
    CLEAR_ON_RESET ? CLEAR : RUN;
  localparam logic [ADDR_W:0] LAST =
    {1'b0, {ADDR_W{1'b1}}};

  state_t          state;
  logic [ADDR_W:0] clr_cnt;
  logic [1:0]      rd_pend;
  logic [1:0]      arb_req;
  logic [1:0]      gnt;
  logic            run;
  logic            clearing;

  // rst_n gates the outputs so reset takes effect
  // without waiting for a clock edge.
  assign run      = rst_n && (state == RUN);
  assign clearing = rst_n && (state == CLEAR);
  assign arb_req  = {req1_valid, req0_valid}
                  & {2{run}};

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (arb_req),
    .advance (run),
    .gnt     (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign rsp0_valid = rd_pend[0];
  assign rsp1_valid = rd_pend[1];
  assign rsp_rdata  = mem_rdata;
  assign init_busy  = (state == CLEAR);

  always_comb begin
    mem_ceb   = 1'b1;
    mem_web   = 1'b1;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      clearing: begin
        mem_ceb  = 1'b0;
        mem_web  = 1'b0;
        mem_addr = clr_cnt[ADDR_W-1:0];
      end
      gnt[0]: begin
        mem_ceb   = 1'b0;
        mem_web   = ~req0_we;
        mem_addr  = req0_addr;
        mem_wdata = req0_wdata;
      end
      gnt[1]: begin
        mem_ceb   = 1'b0;
        mem_web   = ~req1_we;
        mem_addr  = req1_addr;
        mem_wdata = req1_wdata;
      end
      default: begin
        mem_ceb = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RST_ST;
      clr_cnt <= '0;
      rd_pend <= 2'b00;
    end else begin
      rd_pend <= gnt & ~{req1_we, req0_we};
      unique case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST) begin
            state <= RUN;
          end
        end
        RUN: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb_2p.sv
// Directed bench for mem_arb_2p: zero-fill, single
// port, contention, streaming, reset and bypass.
module tb_mem_arb_2p;

  localparam int AW    = 14;
  localparam int DW    = 96;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  `define CHK(tag, obs, exp) \
    begin \
      checks++; \
      assert ((obs) === (exp)) else begin \
        fails++; \
        $error("FAIL %s observed=%0h expected=%0h", \
               tag, obs, exp); \
      end \
    end

  // main instance, zero-fill enabled
  logic          rst_n, v0, we0, v1, we1;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] d0, d1;
  logic          rdy0, rdy1, rv0, rv1;
  logic [DW-1:0] rdata, mwdata;
  logic [DW-1:0] mrdata = '0;
  logic          ceb, web, busy;
  logic [AW-1:0] maddr;

  // bypass instance
  logic          rst_b, v0_b, we0_b, v1_b, we1_b;
  logic [AW-1:0] a0_b, a1_b;
  logic [DW-1:0] d0_b, d1_b;
  logic          rdy0_b, rdy1_b, rv0_b, rv1_b;
  logic [DW-1:0] rdata_b, mwdata_b;
  logic [DW-1:0] mrdata_b = '0;
  logic          ceb_b, web_b, busy_b;
  logic [AW-1:0] maddr_b;

  logic prefill;

  mem_arb_2p u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_ready(rdy0),
    .req0_we(we0), .req0_addr(a0),
    .req0_wdata(d0),
    .req1_valid(v1), .req1_ready(rdy1),
    .req1_we(we1), .req1_addr(a1),
    .req1_wdata(d1),
    .rsp0_valid(rv0), .rsp1_valid(rv1),
    .rsp_rdata(rdata),
    .mem_ceb(ceb), .mem_web(web),
    .mem_addr(maddr), .mem_wdata(mwdata),
    .mem_rdata(mrdata), .init_busy(busy)
  );

  mem_arb_2p #(.CLEAR_ON_RESET(1'b0)) u_byp (
    .clk(clk), .rst_n(rst_b),
    .req0_valid(v0_b), .req0_ready(rdy0_b),
    .req0_we(we0_b), .req0_addr(a0_b),
    .req0_wdata(d0_b),
    .req1_valid(v1_b), .req1_ready(rdy1_b),
    .req1_we(we1_b), .req1_addr(a1_b),
    .req1_wdata(d1_b),
    .rsp0_valid(rv0_b), .rsp1_valid(rv1_b),
    .rsp_rdata(rdata_b),
    .mem_ceb(ceb_b), .mem_web(web_b),
    .mem_addr(maddr_b), .mem_wdata(mwdata_b),
    .mem_rdata(mrdata_b), .init_busy(busy_b)
  );

  // memory models, pre-filled with ones so a
  // missing zero-fill is visible
  logic [DW-1:0] mem_a [0:DEPTH-1];
  logic [DW-1:0] mem_b [0:DEPTH-1];

  always @(posedge clk) begin
    if (prefill) begin
      for (int i = 0; i < DEPTH; i++)
        mem_a[i] <= '1;
    end else if (!ceb) begin
      if (!web) mem_a[maddr] <= mwdata;
      else      mrdata <= mem_a[maddr];
    end
  end

  always @(posedge clk) begin
    if (prefill) begin
      for (int i = 0; i < DEPTH; i++)
        mem_b[i] <= '1;
    end else if (!ceb_b) begin
      if (!web_b) mem_b[maddr_b] <= mwdata_b;
      else        mrdata_b <= mem_b[maddr_b];
    end
  end

  function automatic logic [DW-1:0] sd(int i);
    return {32'hC0DE0000 + i[31:0],
            64'h0123_4567_89AB_CDEF + 64'(i)};
  endfunction

  task automatic fill_wait(output int n,
                           output int bad);
    n   = 0;
    bad = 0;
    while (busy === 1'b1 && n < 20000) begin
      if (maddr !== n[AW-1:0] || ceb !== 1'b0 ||
          web !== 1'b0 || mwdata !== '0)
        bad++;
      if (rdy0 !== 1'b0 || rdy1 !== 1'b0)
        bad++;
      n++;
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bad, seen;
    logic [DW-1:0] db;
    db = 96'hBEEF_0000_1111_2222_3333_4444;

    rst_n = 1'b0; rst_b = 1'b0; prefill = 1'b1;
    v0 = 1'b1; we0 = 1'b0; a0 = 14'h3FFF;
    d0 = '0; v1 = 1'b0; we1 = 1'b0;
    a1 = '0; d1 = '0;
    v0_b = 1'b1; we0_b = 1'b0; a0_b = '0;
    d0_b = '0; v1_b = 1'b0; we1_b = 1'b0;
    a1_b = '0; d1_b = '0;

    repeat (2) @(negedge clk);
    prefill = 1'b0;
    #1;
    `CHK("rst_busy", busy, 1'b1)
    `CHK("rst_rdy0", rdy0, 1'b0)
    `CHK("rst_ceb", ceb, 1'b1)
    `CHK("rst_web", web, 1'b1)
    `CHK("rst_rv0", rv0, 1'b0)
    `CHK("rst_rv1", rv1, 1'b0)
    `CHK("byp_rst_busy", busy_b, 1'b0)
    `CHK("byp_rst_rdy0", rdy0_b, 1'b0)
    `CHK("byp_rst_ceb", ceb_b, 1'b1)

    // bypass: granted right after release
    @(negedge clk);
    rst_b = 1'b1; we0_b = 1'b1;
    a0_b = 14'h0005; d0_b = db;
    #1;
    `CHK("byp_rdy_first", rdy0_b, 1'b1)
    `CHK("byp_busy", busy_b, 1'b0)
    `CHK("byp_web", web_b, 1'b0)
    @(negedge clk);
    we0_b = 1'b0;
    #1;
    `CHK("byp_rd_rdy", rdy0_b, 1'b1)
    `CHK("byp_wr_norsp", rv0_b, 1'b0)
    @(negedge clk);
    v0_b = 1'b0;
    #1;
    `CHK("byp_rsp", rv0_b, 1'b1)
    `CHK("byp_rdata", rdata_b, db)

    // pointer returns to port 0 on reset
    @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1; v0_b = 1'b1; v1_b = 1'b1;
    a1_b = 14'h0006;
    #1;
    `CHK("byp_ptr_rdy0", rdy0_b, 1'b1)
    `CHK("byp_ptr_rdy1", rdy1_b, 1'b0)
    @(negedge clk);
    #1;
    `CHK("byp_alt_rdy0", rdy0_b, 1'b0)
    `CHK("byp_alt_rdy1", rdy1_b, 1'b1)
    @(negedge clk);
    v0_b = 1'b0; v1_b = 1'b0;

    // zero-fill with a port-0 read of 0x3FFF held
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    fill_wait(n, bad);
    `CHK("fill_cycles", n, 16384)
    `CHK("fill_addr_seq", bad, 0)
    `CHK("post_fill_rdy0", rdy0, 1'b1)
    `CHK("post_fill_ceb", ceb, 1'b0)
    `CHK("post_fill_web", web, 1'b1)
    `CHK("post_fill_addr", maddr, 14'h3FFF)
    @(negedge clk);
    v0 = 1'b0;
    #1;
    `CHK("fill_rsp0", rv0, 1'b1)
    `CHK("fill_rdata", rdata, 96'h0)
    `CHK("fill_rsp1", rv1, 1'b0)
    `CHK("idle_ceb", ceb, 1'b1)
    `CHK("idle_web", web, 1'b1)
    `CHK("idle_addr", maddr, 14'h0)
    `CHK("idle_wdata", mwdata, 96'h0)

    // single port 1: write then read same address
    @(negedge clk);
    v1 = 1'b1; we1 = 1'b1;
    a1 = 14'h0010; d1 = 96'hA5A5;
    #1;
    `CHK("sp_wr_rdy1", rdy1, 1'b1)
    `CHK("sp_wr_rdy0", rdy0, 1'b0)
    `CHK("sp_wr_web", web, 1'b0)
    `CHK("sp_wr_addr", maddr, 14'h0010)
    `CHK("sp_wr_wdata", mwdata, 96'hA5A5)
    @(negedge clk);
    we1 = 1'b0;
    #1;
    `CHK("sp_rd_rdy1", rdy1, 1'b1)
    `CHK("sp_rd_web", web, 1'b1)
    `CHK("sp_wr_norsp", rv1, 1'b0)
    @(negedge clk);
    v1 = 1'b0;
    #1;
    `CHK("sp_rsp1", rv1, 1'b1)
    `CHK("sp_rdata", rdata, 96'hA5A5)
    `CHK("sp_rsp0", rv0, 1'b0)
    @(negedge clk);
    #1;
    `CHK("sp_rsp1_once", rv1, 1'b0)

    // preload for contention
    @(negedge clk);
    v0 = 1'b1; we0 = 1'b1;
    a0 = 14'h0020; d0 = sd(20);
    @(negedge clk);
    v0 = 1'b0;
    v1 = 1'b1; we1 = 1'b1;
    a1 = 14'h0021; d1 = sd(21);
    @(negedge clk);
    v1 = 1'b0;

    // contention: both read for 4 cycles
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      v0 = (c < 4); we0 = 1'b0;
      v1 = (c < 4); we1 = 1'b0;
      #1;
      if (c < 4) begin
        `CHK("ct_rdy0", rdy0, (c % 2 == 0))
        `CHK("ct_rdy1", rdy1, (c % 2 == 1))
      end
      if (c > 0) begin
        `CHK("ct_rsp0", rv0, (c % 2 == 1))
        `CHK("ct_rsp1", rv1, (c % 2 == 0))
        `CHK("ct_rdata", rdata,
             (c % 2 == 1) ? sd(20) : sd(21))
      end
    end

    // streaming: 8 writes then 8 reads on port 0
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      v0  = (k < 16);
      we0 = (k < 8);
      a0  = 14'h0100 + 14'(k % 8);
      d0  = sd(100 + (k % 8));
      #1;
      if (k < 16) begin
        `CHK("st_rdy0", rdy0, 1'b1)
      end
      if (k >= 9) begin
        `CHK("st_rsp0", rv0, 1'b1)
        `CHK("st_rdata", rdata, sd(100 + k - 9))
      end else begin
        `CHK("st_norsp", rv0, 1'b0)
      end
    end

    // reset during RUN, then again mid-fill
    @(negedge clk);
    v0 = 1'b1; we0 = 1'b0;
    rst_n = 1'b0;
    #1;
    `CHK("rr_busy", busy, 1'b1)
    `CHK("rr_ceb", ceb, 1'b1)
    `CHK("rr_rdy0", rdy0, 1'b0)
    @(negedge clk);
    rst_n = 1'b1; v0 = 1'b0;
    #1;
    n = 0;
    while (busy === 1'b1 && maddr !== 14'd100 &&
           n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    `CHK("mid_cycles", n, 100)
    `CHK("mid_addr", maddr, 14'd100)
    rst_n = 1'b0;
    #1;
    `CHK("mid_rst_ceb", ceb, 1'b1)
    `CHK("mid_rst_busy", busy, 1'b1)
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    `CHK("restart_addr", maddr, 14'h0)
    `CHK("restart_ceb", ceb, 1'b0)
    fill_wait(n, bad);
    `CHK("refill_cycles", n, 16384)
    `CHK("refill_addr_seq", bad, 0)

    // reset in the cycle after a granted read
    @(negedge clk);
    v0 = 1'b1; we0 = 1'b0; a0 = 14'h0020;
    #1;
    `CHK("pr_rdy0", rdy0, 1'b1)
    @(negedge clk);
    v0 = 1'b0;
    #1;
    `CHK("pr_pending", rv0, 1'b1)
    rst_n = 1'b0;
    #1;
    `CHK("pr_rst_rv0", rv0, 1'b0)
    `CHK("pr_rst_rv1", rv1, 1'b0)
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (rv0 !== 1'b0 || rv1 !== 1'b0) seen++;
      @(negedge clk);
    end
    `CHK("pr_no_rsp", seen, 0)

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule
